// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes plus the memory port 1 signals
// owned by mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int M = 8,
    parameter int K = 10
);
    logic         req0;
    logic         we0;
    logic [K-1:0] addr0;
    logic [M-1:0] wdata0;
    logic         ack0;
    logic [M-1:0] rdata0;

    logic         req1;
    logic         we1;
    logic [K-1:0] addr1;
    logic [M-1:0] wdata1;
    logic         ack1;
    logic [M-1:0] rdata1;

    logic [K-1:0] mem_a;
    logic [M-1:0] mem_wd;
    logic         mem_we;
    logic [M-1:0] mem_rd;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rd,
        output ack0, rdata0, ack1, rdata1,
        output mem_a, mem_wd, mem_we
    );

    // Requester / memory side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rd,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the read/write port of the shared
// scratch memory; one access per three cycles, all outputs registered.
module mem_port_arbiter #(
    parameter int M = 8,
    parameter int K = 10
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t       state;
    logic         gnt;
    logic         last;
    logic [K-1:0] mem_a;
    logic [M-1:0] mem_wd;
    logic         mem_we;
    logic         ack0;
    logic         ack1;
    logic [M-1:0] rdata0;
    logic [M-1:0] rdata1;

    logic         any_req;
    logic         pick;

    // Under contention the requester not served last wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick    = (bus.req0 && bus.req1) ? ~last : bus.req1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= 1'b0;
            last   <= 1'b1;
            mem_a  <= '0;
            mem_wd <= '0;
            mem_we <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt    <= pick;
                        mem_a  <= pick ? bus.addr1  : bus.addr0;
                        mem_wd <= pick ? bus.wdata1 : bus.wdata0;
                        mem_we <= pick ? bus.we1    : bus.we0;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_we still holds the operation type during this cycle.
                    if (!mem_we) begin
                        if (gnt)
                            rdata1 <= bus.mem_rd;
                        else
                            rdata0 <= bus.mem_rd;
                    end
                    ack0   <= ~gnt;
                    ack1   <= gnt;
                    mem_we <= 1'b0;
                    last   <= gnt;
                    state  <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a  = mem_a;
    assign bus.mem_wd = mem_wd;
    assign bus.mem_we = mem_we;
    assign bus.ack0   = ack0;
    assign bus.ack1   = ack1;
    assign bus.rdata0 = rdata0;
    assign bus.rdata1 = rdata1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory instance, transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.M(8), .K(10)) bus ();

    mem_port_arbiter #(.M(8), .K(10)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory instance: combinational read, write on posedge, plus backdoor load.
    logic [7:0] mem [0:1023];
    logic       clr   = 1'b1;
    logic       pl_en = 1'b0;
    logic [9:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_wd;
        end
    end
    assign bus.mem_rd = mem[bus.mem_a];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: tracks each transaction by its age since the grant edge.
    logic [7:0] ref_mem [0:1023];
    int         age   = -1;
    bit         m_gnt = 1'b0;
    bit         m_last = 1'b1;
    bit         t_we  = 1'b0;
    logic [9:0] ea    = '0;
    logic [7:0] ewd   = '0;
    bit         ewe   = 1'b0;
    bit         eack0 = 1'b0;
    bit         eack1 = 1'b0;
    logic [7:0] erd0  = '0;
    logic [7:0] erd1  = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (clr) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        end else if (pl_en) begin
            ref_mem[pl_a] = pl_d;
        end
        if (rst) begin
            age = -1; m_gnt = 0; m_last = 1; t_we = 0;
            ea = '0; ewd = '0; ewe = 0; eack0 = 0; eack1 = 0; erd0 = '0; erd1 = '0;
        end else if (age == 1) begin
            eack0 = 0; eack1 = 0; age = -1;
        end else if (age == 0) begin
            if (t_we) ref_mem[ea] = ewd;
            else if (m_gnt) erd1 = ref_mem[ea];
            else erd0 = ref_mem[ea];
            eack0 = !m_gnt; eack1 = m_gnt; ewe = 0; m_last = m_gnt; age = 1;
        end else if (bus.req0 || bus.req1) begin
            m_gnt = (bus.req0 && bus.req1) ? !m_last : bus.req1;
            ea    = m_gnt ? bus.addr1  : bus.addr0;
            ewd   = m_gnt ? bus.wdata1 : bus.wdata0;
            t_we  = m_gnt ? bus.we1    : bus.we0;
            ewe   = t_we;
            age   = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("mem_a",  32'(bus.mem_a),  32'(ea));
        chk("mem_wd", 32'(bus.mem_wd), 32'(ewd));
        chk("mem_we", 32'(bus.mem_we), 32'(ewe));
        chk("ack0",   32'(bus.ack0),   32'(eack0));
        chk("ack1",   32'(bus.ack1),   32'(eack1));
        chk("rdata0", 32'(bus.rdata0), 32'(erd0));
        chk("rdata1", 32'(bus.rdata1), 32'(erd1));
    end

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_ack(input bit who, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((who ? bus.ack1 : bus.ack0) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_txn(input bit who, input bit we, input logic [9:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int wec, output bit oth);
        int c0;
        bit ok;
        @(negedge clk);
        c0 = cyc;
        if (who) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else     begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        ok = 0; wec = 0; oth = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) wec++;
            if ((who ? bus.ack0 : bus.ack1) === 1'b1) oth = 1;
            if ((who ? bus.ack1 : bus.ack0) === 1'b1) begin ok = 1; break; end
        end
        chk("txn_ack_timeout", 32'(ok), 32'd1);
        lat = cyc - c0;
        rd  = who ? bus.rdata1 : bus.rdata0;
        if (who) bus.req1 = 0; else bus.req0 = 0;
    endtask

    initial begin
        logic [7:0] rd;
        int         lat, wec, first, nack;
        bit         oth, ok, both;
        logic [3:0] ord;
        int         t [4];

        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        preload(10'h001, 8'h5A);
        for (int i = 0; i < 4; i++) preload(10'h010 + 10'(i), 8'h10 + 8'(i));
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_mem_a",  32'(bus.mem_a),  0);
        chk("rst_ack0",   32'(bus.ack0),   0);
        chk("rst_rdata0", 32'(bus.rdata0), 0);

        // Single write then read by requester 0
        do_txn(0, 1, 10'h005, 8'hA5, rd, lat, wec, oth);
        chk("wr_latency", 32'(lat), 2);
        chk("wr_we_cycles", 32'(wec), 1);
        chk("wr_no_ack1", 32'(oth), 0);
        chk("wr_mem", 32'(mem[10'h005]), 'hA5);
        do_txn(0, 0, 10'h005, 8'h00, rd, lat, wec, oth);
        chk("rd_data", 32'(rd), 'hA5);
        chk("rd_latency", 32'(lat), 2);
        chk("rd_no_ack1", 32'(oth), 0);

        // Contention right after reset: requester 0 first, reads old value
        pulse_reset();
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h3FF;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h3FF; bus.wdata1 = 8'h3C;
        first = -1; both = 0; rd = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                first = (bus.ack1 === 1'b1) ? 1 : 0;
                both  = (bus.ack0 === 1'b1) && (bus.ack1 === 1'b1);
                rd    = bus.rdata0;
                break;
            end
        end
        chk("contend_first", 32'(first), 0);
        chk("contend_both", 32'(both), 0);
        chk("contend_old_data", 32'(rd), 0);
        bus.req0 = 0;
        wait_ack(1, 10, ok);
        chk("contend_ack1", 32'(ok), 1);
        bus.req1 = 0;
        do_txn(0, 0, 10'h3FF, 8'h00, rd, lat, wec, oth);
        chk("contend_new_data", 32'(rd), 'h3C);

        // Sustained contention for 12 cycles
        pulse_reset();
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h010;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h011;
        nack = 0; ord = '0; both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both = 1;
            if (bus.ack0 === 1'b1) begin ord = {ord[2:0], 1'b0}; nack++; end
            if (bus.ack1 === 1'b1) begin ord = {ord[2:0], 1'b1}; nack++; end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("rr_ack_count", 32'(nack), 4);
        chk("rr_order", 32'(ord), 'b0101);
        chk("rr_never_both", 32'(both), 0);

        // Back-to-back reads by requester 1
        @(negedge clk);
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h010;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, 10, ok);
            chk("b2b_ack", 32'(ok), 1);
            t[k] = cyc;
            chk("b2b_data", 32'(bus.rdata1), 32'h10 + 32'(k));
            bus.addr1 = 10'h011 + 10'(k);
        end
        bus.req1 = 0;
        for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(t[k] - t[k-1]), 3);

        // Reset asserted during the write cycle
        @(negedge clk);
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'h020; bus.wdata0 = 8'hFF;
        @(negedge clk);
        chk("rstw_we_before", 32'(bus.mem_we), 1);
        bus.req0 = 0;
        #2 rst = 1'b1;
        #1;
        chk("rstw_we_dropped", 32'(bus.mem_we), 0);
        chk("rstw_ack0", 32'(bus.ack0), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rstw_no_write", 32'(mem[10'h020]), 0);
        do_txn(0, 0, 10'h020, 8'h00, rd, lat, wec, oth);
        chk("rstw_idle_latency", 32'(lat), 2);
        chk("rstw_read", 32'(rd), 0);

        // Requester 1 withdraws its read one cycle after the grant
        @(negedge clk);
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h001;
        @(negedge clk);
        bus.req1 = 0;
        wait_ack(1, 5, ok);
        chk("wd_ack1", 32'(ok), 1);
        chk("wd_rdata1", 32'(bus.rdata1), 'h5A);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single read/write port (port 1) of the shared scratch memory: A1, WD1, WE1 and RA1.
- Owns the memory's A1, WD1 and WE1 inputs and returns the RA1 read data to whichever requester is granted.
- Sits between two client engines and the memory instance. The memory's read-only port 2 is not touched and stays directly wired.

Parameters:
- M, 8, memory word width in bits. Must match the memory instance.
- K, 10, address width in bits. Must match the memory instance.

Ports:
- clock, input, 1, system clock. All state updates on posedge.
- reset, input, 1, asynchronous, active-high. Forces every register to its reset value immediately.
- req0, input, 1, requester 0 access request. Held high until ack0.
- we0, input, 1, requester 0 operation: 1 = write, 0 = read.
- addr0, input, K, requester 0 address.
- wdata0, input, M, requester 0 write data.
- ack0, output, 1, one-cycle completion pulse to requester 0.
- rdata0, output, M, read data for requester 0. Valid while ack0 = 1; holds its value afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1: identical set for requester 1.
- mem_a, output, K, drives memory A1.
- mem_wd, output, M, drives memory WD1.
- mem_we, output, 1, drives memory WE1.
- mem_rd, input, M, memory RA1 (combinational read of mem[A1]).

Behaviour:
- Registered outputs: mem_a, mem_wd, mem_we, ack0, ack1, rdata0, rdata1. No combinational path from any input to any output.
- Reset values:
  - FSM = IDLE.
  - mem_a = 0, mem_wd = 0, mem_we = 0.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - Internal gnt = 0 (requester currently served).
  - Internal last = 1 (last requester served), so requester 0 wins the first contention.
- FSM states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Only req0 high: select requester 0. Only req1 high: select requester 1.
  - Both high: select the requester that is not "last".
  - On selection, the posedge loads gnt, mem_a = addrN, mem_wd = wdataN and mem_we = weN, then moves to ACCESS.
- ACCESS (exactly 1 cycle):
  - The memory performs the write at the posedge ending this cycle.
  - For a read, that same posedge captures mem_rd into rdata[gnt].
  - The same edge clears mem_we to 0, sets ack[gnt] = 1, sets last = gnt, and moves to ACK.
  - rdata of a write transaction is unchanged.
- ACK (exactly 1 cycle):
  - ack[gnt] is high for this cycle only.
  - The closing posedge clears ack and returns to IDLE.
  - Requests are not sampled in ACK.
- Latency and throughput:
  - req sampled at edge E: mem_a and mem_we update at E; write commits and ack rises at E+1; ack falls at E+2.
  - Earliest next grant is at E+3. Peak rate is one access per 3 cycles.
- Back-to-back: a requester that keeps req high after its ack is treated as a new request in the next IDLE. Under round-robin it loses to a pending other requester.
- Fairness: with both requests continuously high, grants alternate 0,1,0,1,…
- Withdrawal: req dropping after the grant edge is a protocol violation. The transaction still completes and ack is still pulsed.
- Ordering:
  - Transactions are strictly serialized.
  - A read issued after another requester's write to the same address (write acked first) returns the new data.
  - Port 2 readers see the write from the cycle after the commit edge.
- Address/data: full K-bit address passes through with no bounds check. Wrap-around is the memory's concern.
- Reset mid-operation:
  - mem_we drops immediately. If reset is asserted before the ACCESS commit edge, no write occurs.
  - A pending ack is lost and rdata is cleared. The requester must reissue after reset is released.

Test Plan:
- Single write then read (req0): write addr0 = 0x005, wdata0 = 0xA5. Expect mem_we = 1 for exactly 1 cycle, ack0 two edges after the request edge. Then read addr0 = 0x005 -> rdata0 = 0xA5 with ack0; ack1 never asserts.
- Contention after reset: req0 and req1 both rise in the same cycle (req1 write 0x3FF <- 0x3C, req0 read 0x3FF). Expect requester 0 granted first, reading the old value 0x00. Requester 1 then writes. A following req0 read returns 0x3C.
- Sustained contention: both reqs held high for 12 cycles. Expect grants alternating 0,1,0,1 and exactly 4 acks, one per 3-cycle slot, never both acks high together.
- Back-to-back single requester: req1 held high for 4 reads of 0x010..0x013, preloaded 0x10..0x13. Expect ack1 every 3rd cycle with rdata1 = 0x10, 0x11, 0x12, 0x13.
- Reset mid-write: req0 write 0x020 <- 0xFF; assert reset asynchronously during ACCESS before the edge. Expect mem_we and ack0 to drop immediately, mem[0x020] to remain 0x00, and FSM = IDLE after release.
- Request withdrawn after grant: req1 read of 0x001 dropped one cycle after grant. Expect ack1 still pulsed and rdata1 = mem[0x001].
